// File: rtl/delay_line.sv
// delay_line: DEPTH-stage enabled shift register with valid flags, occupancy count and a selectable tap.
// Revision 1.0
`default_nettype none

module delay_line #(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic [N-1:0]     d,
   input  logic             d_valid,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     q,
   output logic             q_valid,
   output logic [N-1:0]     q_sel,
   output logic             q_sel_valid,
   output logic [4:0]       count,
   output logic             primed
);

   logic [N-1:0]     r_stage [DEPTH] = '{default: '0};
   logic [DEPTH-1:0] r_v             = '0;
   logic [4:0]       r_count         = '0;
   logic [4:0]       w_count_next;

   // Add before subtracting: a departing valid implies count >= 1, so no underflow.
   assign w_count_next = r_count + 5'(d_valid) - 5'(r_v[DEPTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_stage[k] <= '0;
         end
         r_v     <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_v     <= '0;
         r_count <= '0;
      end else if (ce) begin
         r_stage[0] <= d;
         r_v[0]     <= d_valid;
         for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
            r_v[k]     <= r_v[k-1];
         end
         r_count <= w_count_next;
      end
   end

   // Out-of-range selects fall through to the last stage.
   always_comb begin
      q_sel       = r_stage[DEPTH-1];
      q_sel_valid = r_v[DEPTH-1];
      for (int k = 0; k < DEPTH - 1; k++) begin
         if (32'(sel) == k) begin
            q_sel       = r_stage[k];
            q_sel_valid = r_v[k];
         end
      end
   end

   assign q       = r_stage[DEPTH-1];
   assign q_valid = r_v[DEPTH-1];
   assign count   = r_count;
   assign primed  = (r_count == 5'(DEPTH));

endmodule

`default_nettype wire

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter N, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 Parameter SEL_W, default 4, width of the tap-select port; SHALL satisfy 2^SEL_W >= DEPTH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ce  input  1  clock enable; the line advances one stage per edge with ce=1.
REQ-007 flush  input  1  synchronous clear of all valid flags.
REQ-008 d  input  N  data into stage 0.
REQ-009 d_valid  input  1  valid flag accompanying d.
REQ-010 sel  input  SEL_W  tap select; 0 = stage 0 (1-stage delay).
REQ-011 q  output  N  data of stage DEPTH-1 (full delay).
REQ-012 q_valid  output  1  valid flag of stage DEPTH-1.
REQ-013 q_sel  output  N  data of stage sel.
REQ-014 q_sel_valid  output  1  valid flag of stage sel.
REQ-015 count  output  5  number of stages whose valid flag is 1 (0..DEPTH).
REQ-016 primed  output  1  high when count == DEPTH.

Function
REQ-017 State: DEPTH data registers stage[0..DEPTH-1] of N bits, DEPTH valid flags v[0..DEPTH-1], and the count register.
REQ-018 Priority per edge: rst, then flush, then ce.
REQ-019 ce=1, no rst or flush: stage[0]<=d, v[0]<=d_valid, stage[k]<=stage[k-1], v[k]<=v[k-1] for k=1..DEPTH-1.
REQ-020 ce=0, no rst or flush: all data, valid and count registers hold.
REQ-021 Latency: a sample captured at ce-edge n appears on q after DEPTH ce-qualified edges; it appears on q_sel after sel+1 such edges; edges with ce=0 do not count.
REQ-022 q, q_valid SHALL be driven directly from stage[DEPTH-1] and v[DEPTH-1]; there is no combinational path from d to any output.
REQ-023 q_sel and q_sel_valid are a combinational mux of registered stages, driven by sel only.
REQ-024 sel >= DEPTH SHALL clamp to stage DEPTH-1.
REQ-025 A sel change takes effect in the same cycle and does not disturb the stored data.
REQ-026 flush=1: all v[k]<=0 and count<=0; data registers hold; no shift occurs even if ce=1; d and d_valid are discarded that cycle.
REQ-027 Count update on a shift: count <= count + d_valid - v[DEPTH-1], computed without intermediate overflow; count SHALL never exceed DEPTH or fall below 0.
REQ-028 primed is registered-equivalent: derived combinationally from the count register only.
REQ-029 DEPTH=1: stage 0 is both q and q_sel for any sel; behaviour equals a single enabled register with a valid flag.

Reset
REQ-030 rst=1 at an edge: all stage data <=0, all v<=0, count<=0, regardless of ce and flush.
REQ-031 After reset: q=0, q_valid=0, q_sel=0, q_sel_valid=0, count=0, primed=0.
REQ-032 At power-up (before any rst) all registers initialise to 0.
REQ-033 A reset mid-stream discards all in-flight samples; the first ce-edge after rst is released loads stage 0 normally.

Verification
REQ-034 DEPTH=4, N=8; rst for 2 cycles, then ce=1 with d=0x11,0x22,0x33,0x44,0x55 and d_valid=1 -> q=0x11 with q_valid=1 on the 4th edge; count steps 1,2,3,4; primed=1 from the 4th edge.
REQ-035 Same stream with ce=0 for 3 cycles after the 2nd sample -> q, count and all stages frozen; 0x11 reaches q only after 4 ce-qualified edges in total.
REQ-036 Line full (count=4); sweep sel through 0,1,2,3,7 -> q_sel = 0x44,0x33,0x22,0x11,0x11 in the same cycle.
REQ-037 Line full; flush=1 together with ce=1 and d=0x99 -> next cycle count=0, q_valid=0, primed=0, q still 0x11, 0x99 absent from stage 0.
REQ-038 Alternating d_valid=1/0 stream -> count stays within 0..4 and equals the popcount of the v flags every cycle.
REQ-039 rst asserted with ce=1 and flush=1 while the line is full -> next cycle every output is 0.
